// File: rtl/meta_array_arb_pkg.sv
// Shared types and helpers for the MPC per-way metadata array and its arbiter.
package meta_array_arb_pkg;

  typedef struct packed {
    int unsigned metaWidth;
  } mpc_cfg_t;

  localparam mpc_cfg_t Cfg = '{metaWidth: 32'd8};

  // Wide enough for STARVE_MAX up to 15
  localparam int unsigned STARVE_W = 4;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } meta_arb_state_e;

  // Set-index width; never below one bit
  function automatic int unsigned set_w(input int unsigned sets);
    return (sets < 2) ? 1 : $clog2(sets);
  endfunction

endpackage

// File: rtl/meta_arb.sv
// Init/flush walker, starvation-bounded read/write arbiter and SRAM port mux.
module meta_arb
  import meta_array_arb_pkg::*;
#(
  parameter int unsigned       SETS       = 8,
  parameter int unsigned       WAYS       = 4,
  parameter int unsigned       META_W     = Cfg.metaWidth,
  parameter int unsigned       STARVE_MAX = 4,
  parameter logic [META_W-1:0] INIT_VAL   = '0,
  localparam int unsigned      SET_W      = set_w(SETS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_valid,
  input  logic              rd_valid,
  input  logic [SET_W-1:0]  rd_set,
  input  logic              wr_valid,
  input  logic [SET_W-1:0]  wr_set,
  input  logic [WAYS-1:0]   wr_way_en,
  input  logic [META_W-1:0] wr_data,
  output logic              init_busy,
  output logic              rd_ready_c,
  output logic              wr_ready_c,
  output logic              rd_fire_c,
  output logic              rd_oor_c,
  output logic [WAYS-1:0]   sram_cs_c,
  output logic [WAYS-1:0]   sram_we_c,
  output logic [SET_W-1:0]  sram_addr_c,
  output logic [META_W-1:0] sram_wdata_c
);

  meta_arb_state_e     state, state_nx;
  logic [SET_W-1:0]    walk_cnt, walk_nx;
  logic [STARVE_W-1:0] starve_cnt, starve_nx;
  logic                starved;
  logic                wr_oor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      walk_cnt   <= '0;
      starve_cnt <= '0;
      init_busy  <= 1'b1;
    end else begin
      state      <= state_nx;
      walk_cnt   <= walk_nx;
      starve_cnt <= starve_nx;
      init_busy  <= (state_nx == INIT);
    end
  end

  // Next state, arbitration and SRAM port mux
  always_comb begin
    state_nx     = state;
    walk_nx      = walk_cnt;
    starve_nx    = starve_cnt;
    starved      = 1'b0;
    rd_ready_c   = 1'b0;
    wr_ready_c   = 1'b0;
    rd_fire_c    = 1'b0;
    rd_oor_c     = (32'(rd_set) >= SETS);
    wr_oor       = (32'(wr_set) >= SETS);
    sram_cs_c    = '0;
    sram_we_c    = '0;
    sram_addr_c  = '0;
    sram_wdata_c = wr_data;

    case (state)
      INIT: begin
        sram_cs_c    = '1;
        sram_we_c    = '1;
        sram_addr_c  = walk_cnt;
        sram_wdata_c = INIT_VAL;
        starve_nx    = '0;
        if (walk_cnt == SET_W'(SETS - 1)) begin
          state_nx = RUN;
          walk_nx  = '0;
        end else begin
          walk_nx = walk_cnt + SET_W'(1);
        end
      end

      RUN: begin
        if (flush_valid) begin
          state_nx  = INIT;
          walk_nx   = '0;
          starve_nx = '0;
        end else begin
          // Writes win unless the pending read has lost STARVE_MAX times in a row
          starved    = (starve_cnt == STARVE_W'(STARVE_MAX));
          rd_ready_c = !wr_valid || starved;
          wr_ready_c = !starved;
          rd_fire_c  = rd_valid && rd_ready_c;

          if (wr_valid && wr_ready_c) begin
            if (!wr_oor) begin
              sram_cs_c   = wr_way_en;
              sram_we_c   = wr_way_en;
              sram_addr_c = wr_set;
            end
          end else if (rd_fire_c && !rd_oor_c) begin
            sram_cs_c   = '1;
            sram_addr_c = rd_set;
          end

          if (rd_fire_c || !rd_valid) begin
            starve_nx = '0;
          end else if (wr_valid && !starved) begin
            starve_nx = starve_cnt + STARVE_W'(1);
          end
        end
      end

      default: begin
        state_nx = INIT;
        walk_nx  = '0;
      end
    endcase
  end

endmodule

// File: rtl/mpc_sram.sv
// Single-port synchronous SRAM model: write on cs&we, registered read on cs&!we.
module mpc_sram
  import meta_array_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW = set_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (cs && we) begin
      mem[addr] <= wdata;
    end
  end

  // rdata holds its value across write cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (cs && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/meta_array_arb.sv
// Per-way metadata store: arbiter plus one SRAM per way and registered read response.
module meta_array_arb
  import meta_array_arb_pkg::*;
#(
  parameter int unsigned       SETS       = 8,
  parameter int unsigned       WAYS       = 4,
  parameter int unsigned       META_W     = Cfg.metaWidth,
  parameter int unsigned       STARVE_MAX = 4,
  parameter logic [META_W-1:0] INIT_VAL   = '0,
  localparam int unsigned      SET_W      = set_w(SETS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_valid,
  output logic              init_busy,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [SET_W-1:0]  rd_set,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [META_W-1:0] rsp_data [WAYS-1:0],
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [SET_W-1:0]  wr_set,
  input  logic [WAYS-1:0]   wr_way_en,
  input  logic [META_W-1:0] wr_data
);

  logic [WAYS-1:0]   sram_cs;
  logic [WAYS-1:0]   sram_we;
  logic [SET_W-1:0]  sram_addr;
  logic [META_W-1:0] sram_wdata;
  logic [META_W-1:0] sram_rdata [WAYS-1:0];
  logic              rd_fire;
  logic              rd_oor;

  meta_arb #(
    .SETS       (SETS),
    .WAYS       (WAYS),
    .META_W     (META_W),
    .STARVE_MAX (STARVE_MAX),
    .INIT_VAL   (INIT_VAL)
  ) u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_valid  (flush_valid),
    .rd_valid     (rd_valid),
    .rd_set       (rd_set),
    .wr_valid     (wr_valid),
    .wr_set       (wr_set),
    .wr_way_en    (wr_way_en),
    .wr_data      (wr_data),
    .init_busy    (init_busy),
    .rd_ready_c   (rd_ready),
    .wr_ready_c   (wr_ready),
    .rd_fire_c    (rd_fire),
    .rd_oor_c     (rd_oor),
    .sram_cs_c    (sram_cs),
    .sram_we_c    (sram_we),
    .sram_addr_c  (sram_addr),
    .sram_wdata_c (sram_wdata)
  );

  // Out-of-range reads never touch the SRAM; their data is forced to INIT_VAL
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    mpc_sram #(
      .DEPTH (SETS),
      .WIDTH (META_W)
    ) u_sram (
      .clk   (clk),
      .rst_n (rst_n),
      .cs    (sram_cs[w]),
      .we    (sram_we[w]),
      .addr  (sram_addr),
      .wdata (sram_wdata),
      .rdata (sram_rdata[w])
    );

    assign rsp_data[w] = rsp_err ? INIT_VAL : sram_rdata[w];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= rd_fire;
      rsp_err   <= rd_fire && rd_oor;
    end
  end

endmodule

// File: tb/tb_meta_array_arb.sv
// Directed bench for meta_array_arb: an 8-set instance and a 6-set instance with non-zero INIT_VAL.
module tb_meta_array_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;

  logic       flush_valid, rd_valid, wr_valid;
  logic [2:0] rd_set, wr_set;
  logic [3:0] wr_way_en;
  logic [7:0] wr_data;
  logic       init_busy, rd_ready, wr_ready, rsp_valid, rsp_err;
  logic [7:0] rsp_data [3:0];
  logic [31:0] data8;

  logic       flush_valid6, rd_valid6, wr_valid6;
  logic [2:0] rd_set6, wr_set6;
  logic [3:0] wr_way_en6;
  logic [7:0] wr_data6;
  logic       init_busy6, rd_ready6, wr_ready6, rsp_valid6, rsp_err6;
  logic [7:0] rsp_data6 [3:0];
  logic [31:0] data6;

  assign data8 = {rsp_data[3], rsp_data[2], rsp_data[1], rsp_data[0]};
  assign data6 = {rsp_data6[3], rsp_data6[2], rsp_data6[1], rsp_data6[0]};

  meta_array_arb #(.SETS(8), .WAYS(4), .META_W(8), .STARVE_MAX(4), .INIT_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .flush_valid(flush_valid), .init_busy(init_busy),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_set(rd_set),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_set(wr_set),
    .wr_way_en(wr_way_en), .wr_data(wr_data)
  );

  meta_array_arb #(.SETS(6), .WAYS(4), .META_W(8), .STARVE_MAX(4), .INIT_VAL(8'h3C)) dut6 (
    .clk(clk), .rst_n(rst_n), .flush_valid(flush_valid6), .init_busy(init_busy6),
    .rd_valid(rd_valid6), .rd_ready(rd_ready6), .rd_set(rd_set6),
    .rsp_valid(rsp_valid6), .rsp_err(rsp_err6), .rsp_data(rsp_data6),
    .wr_valid(wr_valid6), .wr_ready(wr_ready6), .wr_set(wr_set6),
    .wr_way_en(wr_way_en6), .wr_data(wr_data6)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Counts INIT cycles of both instances starting from the current cycle
  task automatic wait_init(output int c8, output int c6);
    c8 = 0;
    c6 = 0;
    for (int i = 0; i < 40 && init_busy; i++) begin
      c8++;
      if (init_busy6) c6++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c8, c6;
    rst_n = 1'b0;
    flush_valid = 0; rd_valid = 0; wr_valid = 0;
    rd_set = 0; wr_set = 0; wr_way_en = 0; wr_data = 0;
    flush_valid6 = 0; rd_valid6 = 0; wr_valid6 = 0;
    rd_set6 = 0; wr_set6 = 0; wr_way_en6 = 0; wr_data6 = 0;

    tick();
    tick();
    check("rst_busy", init_busy, 1'b1);
    check("rst_rdy", {rd_ready, wr_ready}, 2'b00);
    check("rst_rsp", {rsp_valid, rsp_err}, 2'b00);
    check("rst_busy6", init_busy6, 1'b1);

    rst_n = 1'b1;
    wait_init(c8, c6);
    check("init_cycles8", c8, 8);
    check("init_cycles6", c6, 6);

    // Read of a freshly initialised set
    rd_valid = 1; rd_set = 5;
    settle();
    check("rd_rdy_idle", {rd_ready, wr_ready}, 2'b11);
    tick();
    rd_valid = 0;
    check("rd5", {rsp_valid, rsp_err, data8}, {2'b10, 32'h0000_0000});
    tick();
    check("rsp_one_shot", rsp_valid, 1'b0);

    // Partial-way write followed by an immediate read
    wr_valid = 1; wr_set = 3; wr_way_en = 4'b0101; wr_data = 8'hA5;
    settle();
    check("wr_arb", {rd_ready, wr_ready}, 2'b01);
    tick();
    wr_valid = 0; rd_valid = 1; rd_set = 3;
    tick();
    rd_valid = 0;
    check("wr_rd3", {rsp_valid, rsp_err, data8}, {2'b10, 32'h00A5_00A5});
    tick();

    // Continuous contention: read wins every fifth cycle
    wr_valid = 1; wr_set = 1; wr_way_en = 4'b1111; wr_data = 8'h11;
    rd_valid = 1; rd_set = 3;
    for (int c = 0; c < 10; c++) begin
      settle();
      check("starve_rdy", {rd_ready, wr_ready}, (c % 5 == 4) ? 2'b10 : 2'b01);
      check("starve_rsp", rsp_valid, (c == 5) ? 1'b1 : 1'b0);
      if (c == 5) check("starve_data", data8, 32'h00A5_00A5);
      tick();
    end
    wr_valid = 0; rd_valid = 0;
    check("starve_rsp_end", {rsp_valid, data8}, {1'b1, 32'h00A5_00A5});

    // Zero way enable is accepted and writes nothing
    wr_valid = 1; wr_set = 1; wr_way_en = 4'b0000; wr_data = 8'hFF;
    settle();
    check("wr_en0_rdy", wr_ready, 1'b1);
    tick();
    wr_valid = 0; rd_valid = 1; rd_set = 1;
    tick();
    rd_valid = 0;
    check("wr_en0", {rsp_valid, rsp_err, data8}, {2'b10, 32'h1111_1111});

    // Populate, then flush right after an accepted read
    wr_valid = 1; wr_set = 0; wr_way_en = 4'b1111; wr_data = 8'h5A;
    tick();
    wr_set = 7; wr_way_en = 4'b1000; wr_data = 8'h77;
    tick();
    wr_valid = 0; rd_valid = 1; rd_set = 7;
    settle();
    check("pre_flush_rd", rd_ready, 1'b1);
    tick();
    flush_valid = 1; rd_set = 0;
    settle();
    check("flush_rdy", {rd_ready, wr_ready}, 2'b00);
    check("flush_prev_rsp", {rsp_valid, rsp_err, data8}, {2'b10, 32'h7700_0000});
    tick();
    flush_valid = 0; rd_valid = 0;
    check("flush_no_rsp", rsp_valid, 1'b0);
    wait_init(c8, c6);
    check("flush_cycles", c8, 8);
    rd_valid = 1;
    for (int s = 0; s < 8; s++) begin
      rd_set = 3'(s);
      tick();
      check("flush_set", {rsp_valid, rsp_err, data8}, {2'b10, 32'h0000_0000});
    end
    rd_valid = 0;
    tick();

    // Reset with a response pending drops it
    rd_valid = 1; rd_set = 0;
    tick();
    rd_valid = 0;
    check("rsp_pre_rst", rsp_valid, 1'b1);
    rst_n = 0;
    #1;
    check("rst_drop", {rsp_valid, init_busy, rd_ready, wr_ready}, 4'b0100);
    tick();
    rst_n = 1;
    wait_init(c8, c6);
    check("rst_cycles", c8, 8);

    // Reset at walk step 3 restarts the walk from set 0
    flush_valid = 1;
    tick();
    flush_valid = 0;
    tick();
    tick();
    tick();
    rst_n = 0;
    #1;
    check("rst_mid", {rsp_valid, init_busy}, 2'b01);
    tick();
    rst_n = 1;
    wait_init(c8, c6);
    check("walk_restart8", c8, 8);
    check("walk_restart6", c6, 6);

    // Six-set instance: in-range write, out-of-range write and reads
    wr_valid6 = 1; wr_set6 = 5; wr_way_en6 = 4'b0001; wr_data6 = 8'h42;
    settle();
    check("wr6_rdy", wr_ready6, 1'b1);
    tick();
    wr_set6 = 7; wr_way_en6 = 4'b1111; wr_data6 = 8'h99;
    settle();
    check("oor_wr_rdy", wr_ready6, 1'b1);
    tick();
    wr_valid6 = 0; rd_valid6 = 1;
    for (int s = 0; s < 8; s++) begin
      rd_set6 = 3'(s);
      tick();
      check("sets6_rd", {rsp_valid6, rsp_err6, data6},
            {1'b1, (s >= 6) ? 1'b1 : 1'b0, (s == 5) ? 32'h3C3C_3C42 : 32'h3C3C_3C3C});
    end
    rd_valid6 = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
